// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   NOP_INSTR       : encoding held in IF/ID whenever it carries no real instruction
//   fetch_state_e   : fetch FSM states (RUN, HALT)
//   REDIRECT_CNT_W  : width of the accepted-redirect counter
//   bad_target()    : flags a redirect target that is misaligned or outside the PC range
package fetch_pkg;

    localparam int unsigned INSTR_W        = 32;
    localparam int unsigned REDIRECT_CNT_W = 16;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_e;

    // A target is illegal if it is not word aligned or has bits above the PC width.
    function automatic logic bad_target(input logic [31:0] target, input int unsigned pc_w);
        return (target[1:0] != 2'b00) || ((target >> pc_w) != 32'd0);
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: PC, instruction and valid bit.
//   clk, reset_n      : clock, synchronous active-low reset
//   load              : capture next_pc/next_instr as a valid instruction
//   flush             : kill the held instruction (valid=0, instr=NOP); beats load
//   next_pc/next_instr: incoming fetch slot
//   pc/instr/valid    : registered IF/ID contents
// With neither load nor flush the register holds all fields.
module if_id_reg
    import fetch_pkg::*;
#(
    parameter int unsigned PC_W = 9
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load,
    input  logic               flush,
    input  logic [PC_W-1:0]    next_pc,
    input  logic [INSTR_W-1:0] next_instr,
    output logic [PC_W-1:0]    pc,
    output logic [INSTR_W-1:0] instr,
    output logic               valid
);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc    <= '0;
            instr <= NOP_INSTR;
            valid <= 1'b0;
        end else if (flush) begin
            // PC is left as-is; it is meaningless while valid is low.
            instr <= NOP_INSTR;
            valid <= 1'b0;
        end else if (load) begin
            pc    <= next_pc;
            instr <= next_instr;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: program counter, fetch FSM and IF/ID register.
//   clk, reset_n   : clock, synchronous active-low reset
//   stall          : hold PC and IF/ID (ignored when a redirect is present)
//   pc_sel, br_pc  : redirect request and target from the branch unit
//   imem_addr      : combinational address to synchronous instruction memory
//   imem_rdata     : instruction at pc_q (address issued the previous cycle)
//   if_id_pc/instr/valid : IF/ID register contents
//   flush_ex       : combinational kill of the ID/EX register at this edge
//   fetch_halted   : registered HALT indication
//   halt_addr      : illegal target captured on entry to HALT
//   redirect_cnt   : saturating count of accepted redirects
module fetch_pc_unit
    import fetch_pkg::*;
#(
    parameter int unsigned     PC_W     = 9,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      stall,
    input  logic                      pc_sel,
    input  logic [31:0]               br_pc,
    output logic [PC_W-1:0]           imem_addr,
    input  logic [INSTR_W-1:0]        imem_rdata,
    output logic [PC_W-1:0]           if_id_pc,
    output logic [INSTR_W-1:0]        if_id_instr,
    output logic                      if_id_valid,
    output logic                      flush_ex,
    output logic                      fetch_halted,
    output logic [31:0]               halt_addr,
    output logic [REDIRECT_CNT_W-1:0] redirect_cnt
);

    fetch_state_e    state;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_next;
    logic            redirect_ok;
    logic            redirect_bad;
    logic            advance;
    logic            kill;

    // Redirect / stall / advance decode; redirect has priority over stall.
    always_comb begin
        pc_next      = pc_q;
        redirect_ok  = 1'b0;
        redirect_bad = 1'b0;
        advance      = 1'b0;
        if (state == RUN) begin
            if (pc_sel) begin
                if (bad_target(br_pc, PC_W)) begin
                    redirect_bad = 1'b1;
                end else begin
                    redirect_ok = 1'b1;
                    pc_next     = br_pc[PC_W-1:0];
                end
            end else if (!stall) begin
                advance = 1'b1;
                pc_next = pc_q + PC_W'(4);
            end
        end
    end

    assign kill = redirect_ok | redirect_bad;

    // Issuing RESET_PC during reset makes imem_rdata valid on the first run cycle.
    assign imem_addr = reset_n ? pc_next : RESET_PC;
    assign flush_ex  = reset_n & kill;

    // FSM, PC, halt capture and redirect counter.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= RUN;
            pc_q         <= RESET_PC;
            fetch_halted <= 1'b0;
            halt_addr    <= '0;
            redirect_cnt <= '0;
        end else begin
            pc_q <= pc_next;
            case (state)
                RUN: begin
                    if (redirect_bad) begin
                        state        <= HALT;
                        fetch_halted <= 1'b1;
                        halt_addr    <= br_pc;
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= HALT;
                end
            endcase
            if (redirect_ok && (redirect_cnt != {REDIRECT_CNT_W{1'b1}})) begin
                redirect_cnt <= redirect_cnt + REDIRECT_CNT_W'(1);
            end
        end
    end

    if_id_reg #(
        .PC_W (PC_W)
    ) u_if_id_reg (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (advance),
        .flush      (kill),
        .next_pc    (pc_q),
        .next_instr (imem_rdata),
        .pc         (if_id_pc),
        .instr      (if_id_instr),
        .valid      (if_id_valid)
    );

endmodule
